// File: rtl/dram_arb_pkg.sv
// Shared types for the data-RAM arbiter: requester identity, FSM states and
// the byte-strobe width used on every write-enable port.
package dram_arb_pkg;

   localparam int unsigned STRB_W = 4;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_e;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dram_arb_perf.sv
// Saturating performance counters for the data-RAM arbiter.
// Compiled only when DRAM_ARB_PERF_EN is defined.
`ifdef DRAM_ARB_PERF_EN
module dram_arb_perf
   import dram_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        dbg_gnt_i,
   output logic [31:0] perf_cpu_stall_o,
   output logic [31:0] perf_dbg_gnt_o
);

   // Count CPU stall cycles and debug grants, holding at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_cpu_stall_o <= '0;
         perf_dbg_gnt_o   <= '0;
      end else begin
         if (stall_i && (perf_cpu_stall_o != '1))
            perf_cpu_stall_o <= perf_cpu_stall_o + 32'd1;
         if (dbg_gnt_i && (perf_dbg_gnt_o != '1))
            perf_dbg_gnt_o <= perf_dbg_gnt_o + 32'd1;
      end
   end

endmodule
`endif

// File: rtl/dram_arbiter.sv
// Data-RAM arbiter between the CPU MEM-stage port and the debug/loader port.
// Round-robin on contention, debug lock with a bounded CPU starvation window,
// one-cycle read return to the owning requester.
// Optional feature macro: DRAM_ARB_PERF_EN (adds stall / debug-grant counters).
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LOCK_MAX   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req_i,
   input  logic [STRB_W-1:0]     cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic                  cpu_gnt_o,
   output logic                  cpu_rvalid_o,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  stall_o,
   input  logic                  dbg_req_i,
   input  logic [STRB_W-1:0]     dbg_we_i,
   input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
   input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
   input  logic                  dbg_lock_i,
   output logic                  dbg_gnt_o,
   output logic                  dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0] dbg_rdata_o,
`ifdef DRAM_ARB_PERF_EN
   output logic [31:0]           perf_cpu_stall_o,
   output logic [31:0]           perf_dbg_gnt_o,
`endif
   output logic                  mem_en_o,
   output logic [STRB_W-1:0]     mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

   arb_state_e            state_q;
   owner_e                last_gnt_q;
   logic [7:0]            lock_cnt_q;
   logic                  rd_pending_q;
   owner_e                rd_owner_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] dbg_rdata_q;

   logic cpu_gnt;
   logic dbg_gnt;
   logic cpu_rd;
   logic dbg_rd;

   // Per-cycle grant decision; nothing is granted while reset is held.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (rst_n) begin
         if ((state_q == LOCK) && dbg_lock_i) begin
            // Debug owns the RAM, except for one forced CPU slot after
            // LOCK_MAX locked debug grants, or when debug is idle.
            if ((lock_cnt_q == LOCK_MAX_C) && cpu_req_i)
               cpu_gnt = 1'b1;
            else if (dbg_req_i)
               dbg_gnt = 1'b1;
            else
               cpu_gnt = cpu_req_i;
         end else begin
            // Round-robin; a lock-release cycle in LOCK is arbitrated here too.
            if (cpu_req_i && dbg_req_i) begin
               if (last_gnt_q == OWN_DBG)
                  cpu_gnt = 1'b1;
               else
                  dbg_gnt = 1'b1;
            end else begin
               cpu_gnt = cpu_req_i;
               dbg_gnt = dbg_req_i;
            end
         end
      end
   end

   assign cpu_gnt_o = cpu_gnt;
   assign dbg_gnt_o = dbg_gnt;
   assign stall_o   = cpu_req_i & ~cpu_gnt;

   assign cpu_rd = cpu_gnt && (cpu_we_i == '0);
   assign dbg_rd = dbg_gnt && (dbg_we_i == '0);

   // Route the granted requester onto the RAM port; quiet when idle.
   always_comb begin
      mem_en_o    = cpu_gnt | dbg_gnt;
      mem_we_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (dbg_gnt) begin
         mem_we_o    = dbg_we_i;
         mem_addr_o  = dbg_addr_i;
         mem_wdata_o = dbg_wdata_i;
      end else if (cpu_gnt) begin
         mem_we_o    = cpu_we_i;
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
      end
   end

   // Arbitration FSM: round-robin history, lock entry/exit and lock counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ARB;
         last_gnt_q <= OWN_DBG;
         lock_cnt_q <= '0;
      end else begin
         if (cpu_gnt)
            last_gnt_q <= OWN_CPU;
         else if (dbg_gnt)
            last_gnt_q <= OWN_DBG;

         case (state_q)
            ARB: begin
               // The grant that takes the lock is the first locked debug grant.
               if (dbg_lock_i && dbg_gnt) begin
                  state_q    <= LOCK;
                  lock_cnt_q <= 8'd1;
               end
            end
            LOCK: begin
               if (!dbg_lock_i) begin
                  state_q    <= ARB;
                  lock_cnt_q <= '0;
               end else if (cpu_gnt && (lock_cnt_q == LOCK_MAX_C)) begin
                  lock_cnt_q <= '0;
               end else if (dbg_gnt && (lock_cnt_q != LOCK_MAX_C)) begin
                  lock_cnt_q <= lock_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q    <= ARB;
               lock_cnt_q <= '0;
            end
         endcase
      end
   end

   // Read tracking: remember who owns the data returning next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pending_q <= 1'b0;
         rd_owner_q   <= OWN_CPU;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         rd_pending_q <= cpu_rd | dbg_rd;
         rd_owner_q   <= dbg_gnt ? OWN_DBG : OWN_CPU;
         if (cpu_rvalid_o)
            cpu_rdata_q <= mem_rdata_i;
         if (dbg_rvalid_o)
            dbg_rdata_q <= mem_rdata_i;
      end
   end

   // Read data passes straight through in the return cycle, held otherwise.
   assign cpu_rvalid_o = rst_n & rd_pending_q & (rd_owner_q == OWN_CPU);
   assign dbg_rvalid_o = rst_n & rd_pending_q & (rd_owner_q == OWN_DBG);
   assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
   assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : dbg_rdata_q;

`ifdef DRAM_ARB_PERF_EN
   dram_arb_perf u_perf (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_i          (stall_o),
      .dbg_gnt_i        (dbg_gnt),
      .perf_cpu_stall_o (perf_cpu_stall_o),
      .perf_dbg_gnt_o   (perf_dbg_gnt_o)
   );
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter (LOCK_MAX = 4) with a
// behavioural one-cycle RAM and a read-data scoreboard per port.
module tb_dram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpu_req_i;
   logic [3:0]  cpu_we_i;
   logic [15:0] cpu_addr_i;
   logic [31:0] cpu_wdata_i;
   logic        cpu_gnt_o;
   logic        cpu_rvalid_o;
   logic [31:0] cpu_rdata_o;
   logic        stall_o;
   logic        dbg_req_i;
   logic [3:0]  dbg_we_i;
   logic [15:0] dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_lock_i;
   logic        dbg_gnt_o;
   logic        dbg_rvalid_o;
   logic [31:0] dbg_rdata_o;
   logic        mem_en_o;
   logic [3:0]  mem_we_o;
   logic [15:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
`ifdef DRAM_ARB_PERF_EN
   logic [31:0] perf_cpu_stall_o;
   logic [31:0] perf_dbg_gnt_o;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   dram_arbiter #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (32),
      .LOCK_MAX   (4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_req_i        (cpu_req_i),
      .cpu_we_i         (cpu_we_i),
      .cpu_addr_i       (cpu_addr_i),
      .cpu_wdata_i      (cpu_wdata_i),
      .cpu_gnt_o        (cpu_gnt_o),
      .cpu_rvalid_o     (cpu_rvalid_o),
      .cpu_rdata_o      (cpu_rdata_o),
      .stall_o          (stall_o),
      .dbg_req_i        (dbg_req_i),
      .dbg_we_i         (dbg_we_i),
      .dbg_addr_i       (dbg_addr_i),
      .dbg_wdata_i      (dbg_wdata_i),
      .dbg_lock_i       (dbg_lock_i),
      .dbg_gnt_o        (dbg_gnt_o),
      .dbg_rvalid_o     (dbg_rvalid_o),
      .dbg_rdata_o      (dbg_rdata_o),
`ifdef DRAM_ARB_PERF_EN
      .perf_cpu_stall_o (perf_cpu_stall_o),
      .perf_dbg_gnt_o   (perf_dbg_gnt_o),
`endif
      .mem_en_o         (mem_en_o),
      .mem_we_o         (mem_we_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_rdata_i      (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: read-first, byte-write, data one cycle after address.
   logic [31:0] ram [0:255];
   logic [31:0] ram_q;
   logic        ram_ready = 1'b0;
   assign mem_rdata_i = ram_q;

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
         ram_ready <= 1'b1;
         ram_q     <= '0;
      end else if (mem_en_o) begin
         ram_q <= ram[mem_addr_o[7:0]];
         for (int b = 0; b < 4; b++)
            if (mem_we_o[b]) ram[mem_addr_o[7:0]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end
   end

   // Bench-side expectations.
   logic [31:0] exp_mem [0:255];
   logic [31:0] cq [$];
   logic [31:0] dq [$];
   logic        exp_crv = 1'b0;
   logic        exp_drv = 1'b0;
   logic [31:0] exp_clast = '0;
   logic [31:0] exp_dlast = '0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // One clock cycle: drive at posedge+1, check at negedge, predict returns.
   task automatic cyc(input string tag,
                      input logic c_req, input logic [3:0] c_we, input logic [15:0] c_addr,
                      input logic [31:0] c_wd,
                      input logic d_req, input logic [3:0] d_we, input logic [15:0] d_addr,
                      input logic [31:0] d_wd, input logic d_lock,
                      input logic exp_c, input logic exp_d);
      cpu_req_i = c_req; cpu_we_i = c_we; cpu_addr_i = c_addr; cpu_wdata_i = c_wd;
      dbg_req_i = d_req; dbg_we_i = d_we; dbg_addr_i = d_addr; dbg_wdata_i = d_wd;
      dbg_lock_i = d_lock;
      @(negedge clk);
      chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid_o), 32'(exp_crv));
      chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid_o), 32'(exp_drv));
      if (exp_crv && cq.size() > 0) exp_clast = cq.pop_front();
      if (exp_drv && dq.size() > 0) exp_dlast = dq.pop_front();
      chk({tag, ".cpu_rdata"}, cpu_rdata_o, exp_clast);
      chk({tag, ".dbg_rdata"}, dbg_rdata_o, exp_dlast);
      chk({tag, ".cpu_gnt"}, 32'(cpu_gnt_o), 32'(exp_c));
      chk({tag, ".dbg_gnt"}, 32'(dbg_gnt_o), 32'(exp_d));
      chk({tag, ".stall"}, 32'(stall_o), 32'(c_req & ~exp_c));
      chk({tag, ".mem_en"}, 32'(mem_en_o), 32'(exp_c | exp_d));
      if (exp_c) begin
         chk({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(c_addr));
         chk({tag, ".mem_we"}, 32'(mem_we_o), 32'(c_we));
      end
      if (exp_d) begin
         chk({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(d_addr));
         chk({tag, ".mem_we"}, 32'(mem_we_o), 32'(d_we));
      end
      exp_crv = exp_c && (c_we == 4'd0);
      exp_drv = exp_d && (d_we == 4'd0);
      if (exp_crv) cq.push_back(exp_mem[c_addr[7:0]]);
      if (exp_drv) dq.push_back(exp_mem[d_addr[7:0]]);
      if (exp_c && c_we != 4'd0) exp_mem[c_addr[7:0]] = merge(exp_mem[c_addr[7:0]], c_wd, c_we);
      if (exp_d && d_we != 4'd0) exp_mem[d_addr[7:0]] = merge(exp_mem[d_addr[7:0]], d_wd, d_we);
      @(posedge clk);
      #1;
   endtask

   task automatic rd2(input string tag, input logic c_req, input logic [15:0] c_addr,
                      input logic d_req, input logic [15:0] d_addr, input logic d_lock,
                      input logic exp_c, input logic exp_d);
      cyc(tag, c_req, 4'd0, c_addr, 32'd0, d_req, 4'd0, d_addr, 32'd0, d_lock, exp_c, exp_d);
   endtask

   // One reset cycle; pending reads are dropped and outputs return to reset values.
   task automatic do_reset(input string tag);
      cpu_req_i = 1'b0; cpu_we_i = '0; cpu_addr_i = '0; cpu_wdata_i = '0;
      dbg_req_i = 1'b0; dbg_we_i = '0; dbg_addr_i = '0; dbg_wdata_i = '0;
      dbg_lock_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid_o), 32'd0);
      chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid_o), 32'd0);
      chk({tag, ".cpu_gnt"}, 32'(cpu_gnt_o), 32'd0);
      chk({tag, ".dbg_gnt"}, 32'(dbg_gnt_o), 32'd0);
      @(posedge clk);
      #1;
      cq.delete(); dq.delete();
      exp_crv = 1'b0; exp_drv = 1'b0; exp_clast = '0; exp_dlast = '0;
      chk({tag, ".cpu_rdata"}, cpu_rdata_o, 32'd0);
      chk({tag, ".dbg_rdata"}, dbg_rdata_o, 32'd0);
      chk({tag, ".cpu_rvalid_after"}, 32'(cpu_rvalid_o), 32'd0);
      chk({tag, ".mem_en"}, 32'(mem_en_o), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:9] lock_pat;
      int unsigned nc;
      int unsigned nd;
      logic ec;

      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 32'hA500_0000 | 32'(i);

      // Reset, then simultaneous reads: CPU first, debug next.
      do_reset("rst0");
      rd2("rs1", 1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, 1'b1, 1'b0);
      rd2("rs2", 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b1);
      rd2("rs3", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Continuous contention for 10 cycles, starting from reset history.
      do_reset("rst1");
      for (int i = 0; i < 10; i++) begin
         ec = ((i % 2) == 0);
         rd2($sformatf("cont%0d", i), 1'b1, 16'h0040 + 16'((i + 1) / 2),
             1'b1, 16'h0080 + 16'(i / 2), 1'b0, ec, ~ec);
      end
`ifdef DRAM_ARB_PERF_EN
      chk("perf_cpu_stall", perf_cpu_stall_o, 32'd5);
      chk("perf_dbg_gnt", perf_dbg_gnt_o, 32'd5);
`endif
      rd2("cont_flush", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      // Write then read, including a partial byte write.
      cyc("wr_dbg", 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'hF, 16'h0004, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      rd2("rd_cpu1", 1'b1, 16'h0004, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      cyc("wr_cpu", 1'b1, 4'h1, 16'h0004, 32'h000000AA, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      rd2("rd_cpu2", 1'b1, 16'h0004, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      rd2("wr_flush", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("rd_merged", exp_clast, 32'hDEADBEAA);

      // Lock: entry grant counts as the first of 4 debug grants, then 1 CPU.
      rd2("lk_in", 1'b0, 16'h0, 1'b1, 16'h00C0, 1'b1, 1'b0, 1'b1);
      lock_pat = 10'b0001000010;
      nc = 0;
      nd = 1;
      for (int k = 0; k < 10; k++) begin
         rd2($sformatf("lk%0d", k), 1'b1, 16'h0060 + 16'(nc), 1'b1, 16'h00C0 + 16'(nd),
             1'b1, lock_pat[k], ~lock_pat[k]);
         if (lock_pat[k]) nc++; else nd++;
      end
      // Dropping the lock arbitrates round-robin in that same cycle.
      rd2("lk_drop", 1'b1, 16'h0060 + 16'(nc), 1'b1, 16'h00C0 + 16'(nd), 1'b0, 1'b1, 1'b0);
      rd2("lk_arb", 1'b1, 16'h0061 + 16'(nc), 1'b1, 16'h00C0 + 16'(nd), 1'b0, 1'b0, 1'b1);

      // Idle debug port inside LOCK lets the CPU in without ending the lock.
      rd2("li_in", 1'b0, 16'h0, 1'b1, 16'h0011, 1'b1, 1'b0, 1'b1);
      rd2("li_cpu", 1'b1, 16'h0012, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      rd2("li_d1", 1'b1, 16'h0013, 1'b1, 16'h0014, 1'b1, 1'b0, 1'b1);
      rd2("li_d2", 1'b1, 16'h0013, 1'b1, 16'h0015, 1'b1, 1'b0, 1'b1);
      rd2("li_out", 1'b1, 16'h0013, 1'b1, 16'h0016, 1'b0, 1'b1, 1'b0);
      rd2("li_arb", 1'b0, 16'h0, 1'b1, 16'h0016, 1'b0, 1'b0, 1'b1);

      // Lock without a debug request has no effect in ARB.
      rd2("nl_idle", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      rd2("nl_rr", 1'b1, 16'h0017, 1'b1, 16'h0018, 1'b1, 1'b1, 1'b0);
      rd2("nl_in", 1'b1, 16'h0019, 1'b1, 16'h0018, 1'b1, 1'b0, 1'b1);
      rd2("nl_out", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      // Reset in the cycle after a CPU read grant drops the return.
      rd2("mr_rd", 1'b1, 16'h0030, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      do_reset("mr_rst");
      rd2("mr_post", 1'b1, 16'h0031, 1'b1, 16'h0032, 1'b0, 1'b1, 1'b0);
      rd2("mr_post2", 1'b0, 16'h0, 1'b1, 16'h0032, 1'b0, 1'b0, 1'b1);
      rd2("mr_flush", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
